// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands one nibble per clock,
// least significant nibble first, behind a valid/ready handshake.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   finalsum,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             carry_reg, carry_next;
    logic [KW-1:0]    k_reg, k_next;

    // Nibble views of the latched operands and the sum with the current
    // nibble replaced by the adder result.
    logic [3:0]       a_nib [NIB];
    logic [3:0]       b_nib [NIB];
    logic [WIDTH-1:0] sum_upd;
    logic [4:0]       t;

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
            assign sum_upd[4*gi +: 4] = (k_reg == KW'(gi)) ? t[3:0]
                                                           : sum_reg[4*gi +: 4];
        end
    endgenerate

    // The single 4-bit add cell shared by every nibble.
    assign t = {1'b0, a_nib[k_reg]} + {1'b0, b_nib[k_reg]} + {4'b0000, carry_reg};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept, walk NIB nibbles, hold until consumed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)          state_next = ADD;
            ADD:     if (k_reg == K_LAST)   state_next = DONE;
            DONE:    if (out_ready)         state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Handshake and result outputs decoded from state and datapath registers.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        busy      = (state_reg == ADD);
        out_valid = (state_reg == DONE);
        sum       = sum_reg;
        cout      = cout_reg;
        finalsum  = {cout_reg, sum_reg};
    end

    // Datapath next values: operands latched only on accept; results are
    // cleared at accept so a stale sum never mixes with the new one.
    always_comb begin
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        carry_next = carry_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = A;
                    b_next     = B;
                    sum_next   = '0;
                    cout_next  = 1'b0;
                    carry_next = cin;
                    k_next     = '0;
                end
            end
            ADD: begin
                sum_next   = sum_upd;
                carry_next = t[4];
                k_next     = k_reg + 1'b1;
                // The top carry leaves only through cout; it is never
                // recirculated into nibble 0.
                if (k_reg == K_LAST) begin
                    cout_next = t[4];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            carry_reg <= 1'b0;
            k_reg     <= '0;
        end else begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            carry_reg <= carry_next;
            k_reg     <= k_next;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: scoreboard of expected A+B+cin values,
// checked by an independent monitor whenever a result becomes valid.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH:0]   finalsum;
    logic             busy;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .finalsum  (finalsum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [WIDTH:0] exp_q [$];
    int             acc_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard.
    logic           prev_ov = 1'b0;
    logic [WIDTH:0] mon_exp;
    int             mon_acc;
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                $display("result: sum=0x%04h cout=%0d finalsum=0x%05h expected=0x%05h latency=%0d",
                         sum, cout, finalsum, mon_exp, cyc - mon_acc);
                chk("finalsum", 32'(finalsum), 32'(mon_exp));
                chk("sum", 32'(sum), 32'(mon_exp[WIDTH-1:0]));
                chk("cout", 32'(cout), 32'(mon_exp[WIDTH]));
                chk("latency", 32'(cyc - mon_acc), 32'(NIB));
            end
        end
        prev_ov = out_valid;
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, output int acc);
        int n = 0;
        A = a; B = b; cin = ci; in_valid = 1'b1;
        acc = -1;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("issue_timeout", 32'd0, 32'd1);
                return;
            end
        end
        acc = cyc + 1;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci});
        acc_q.push_back(acc);
        $display("issue: A=0x%04h B=0x%04h cin=%0d accept_cycle=%0d", a, b, ci, acc);
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                chk("wait_valid_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic ci, input int stall);
        int acc;
        out_ready = (stall == 0);
        issue(a, b, ci, acc);
        in_valid = 1'b0;
        wait_valid();
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, acc;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finalsum", 32'(finalsum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add and carry-in paths.
        run_op(16'h0002, 16'h0003, 1'b0, 0);
        run_op(16'hCCCC, 16'hFFFF, 1'b1, 0);
        run_op(16'h000F, 16'h0000, 1'b1, 0);

        // Full ripple: carry register must be 1 after every nibble.
        out_ready = 1'b1;
        issue(16'hFFFF, 16'h0001, 1'b0, acc);
        in_valid = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            chk($sformatf("ripple_carry_nib%0d", i), 32'(dut.carry_reg), 32'd1);
        end
        @(negedge clk);

        // Backpressure and input isolation.
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, acc);
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
            in_valid = (i % 2 == 0);
            @(negedge clk);
            chk("bp_sum", 32'(sum), 32'h5555);
            chk("bp_finalsum", 32'(finalsum), 32'h05555);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_sum_kept", 32'(sum), 32'h5555);
        chk("bp_no_accept", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of ADD.
        issue(16'h1111, 16'h2222, 1'b0, acc);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted at cycle %0d", cyc);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_finalsum", 32'(finalsum), 32'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0A0B, 16'h0101, 1'b0, 0);

        // Randomized operations with random backpressure.
        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Back-to-back throughput.
        out_ready = 1'b1;
        issue(16'h000A, 16'h000B, 1'b0, a1);
        issue(16'h8000, 16'h8000, 1'b0, a2);
        issue(16'h0000, 16'h0000, 1'b0, a3);
        in_valid = 1'b0;
        chk("b2b_spacing_1", 32'(a2 - a1), 32'(NIB + 2));
        chk("b2b_spacing_2", 32'(a3 - a2), 32'(NIB + 2));
        wait_valid();
        @(negedge clk);
        @(negedge clk);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder that adds two WIDTH-bit operands one 4-bit nibble per clock, least significant nibble first.
- Carry is held in a register between nibbles.
- Sits at the front of the adder datapath. It turns a single 4-bit add cell into a wide adder behind a valid/ready handshake.
- Its output set (sum, cout, finalsum) matches the 4-bit ripple-carry adder's output format, widened to WIDTH.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, number of nibbles per operation (derived, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands A, B, cin are valid this cycle
in_ready  output  1  block can accept a new operation
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  result is valid and held
out_ready  input  1  consumer accepts the result this cycle
sum  output  WIDTH  registered sum, A+B+cin mod 2^WIDTH
cout  output  1  carry-out of the most significant nibble
finalsum  output  WIDTH+1  {cout, sum}
busy  output  1  high in ADD state

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum, cout, finalsum, carry register, nibble index, operand registers all 0.
  - Takes effect immediately, including mid-ADD or in DONE. Any partial result is discarded.
- States: IDLE, ADD, DONE. in_ready = (state==IDLE). busy = (state==ADD). out_valid = (state==DONE).
- IDLE:
  - On a rising edge with in_valid&&in_ready, latch A, B, cin into internal registers.
  - Clear sum and cout to 0, set nibble index k=0, carry=cin, go to ADD.
- ADD, one nibble per edge:
  - t = A[4k+3:4k] + B[4k+3:4k] + carry, a 5-bit result.
  - sum[4k+3:4k] <= t[3:0]; carry <= t[4]; k <= k+1.
  - On the edge processing k=NIB-1: cout <= t[4], go to DONE.
- Latency: out_valid rises NIB cycles after the accept edge (4 cycles for WIDTH=16).
- DONE:
  - sum, cout and finalsum are stable while out_valid=1 and out_ready=0 (backpressure can last indefinitely).
  - On an edge with out_ready=1, go to IDLE.
  - sum, cout and finalsum keep their values until the next accept.
- No same-cycle handoff: in_ready rises the cycle after result acceptance. Throughput is one operation per NIB+2 cycles with in_valid and out_ready held high.
- Input side:
  - A, B and cin are sampled only at the accept edge. Changes during ADD or DONE are ignored.
  - in_valid while not in_ready is ignored. Upstream must hold the request until in_ready.
- Arithmetic: unsigned. finalsum = {cout, sum} = A+B+cin exactly; its maximum is 2^(WIDTH+1)-1.
- out_ready while not out_valid: no effect.
- Carry chain wrap: a carry out of nibble NIB-1 appears only on cout. It never feeds back into nibble 0.

Test Plan:
- Basic add (WIDTH=16): A=0x0002, B=0x0003, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x0005, cout=0, finalsum=0x00005.
- Full carry ripple: A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, finalsum=0x10000. Check the carry register is 1 after each of nibbles 0..3.
- Carry-in path: A=0xCCCC, B=0xFFFF, cin=1 -> sum=0xCCCC, cout=1, finalsum=0x1CCCC. Also A=0x000F, B=0x0000, cin=1 -> sum=0x0010, cout=0.
- Backpressure and input isolation:
  - Stimulus: result for 0x1234+0x4321 with out_ready=0 for 5 cycles. Meanwhile toggle A/B and pulse in_valid.
  - Required: sum stays 0x5555, out_valid=1, in_ready=0, no new accept.
  - Then raise out_ready: IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 asynchronously during ADD at k=2 -> all outputs 0 and in_ready=1 immediately without a clock edge. A fresh operation 0x0A0B+0x0101 then gives 0x0B0C.
- Back-to-back throughput: three ops with in_valid=1 and out_ready=1 continuously -> accepts spaced exactly 6 cycles apart.
  - 0x000A+0x000B -> 0x0015.
  - 0x8000+0x8000 -> sum 0x0000, cout 1.
  - 0x0000+0x0000 -> 0.
